// File: rtl/multi_edge_detect.sv
// Per-channel synchronizer, debounce filter and edge detector for asynchronous level inputs.
// Each channel emits a one-cycle pulse, a sticky flag and a saturating count of selected edges.
module multi_edge_detect #(
    parameter int NCH    = 4,
    parameter int N_SYNC = 2,
    parameter int DB_CYC = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCH-1:0]       level_in,
    input  logic [2*NCH-1:0]     mode,
    input  logic [NCH-1:0]       clr_sticky,
    input  logic [NCH-1:0]       clr_cnt,
    output logic [NCH-1:0]       pulse_out,
    output logic [NCH-1:0]       sticky_out,
    output logic [NCH-1:0]       level_filt,
    output logic [NCH*CNT_W-1:0] edge_cnt
);

    localparam int               DB_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [N_SYNC-1:0] sync;
        logic              s;
        logic              f;
        logic              f_d;
        logic [DB_W-1:0]   c;
        logic              rise;
        logic              fall;
        logic              evt;
        logic              pulse_q;
        logic              sticky_q;
        logic [CNT_W-1:0]  cnt_q;

        assign s = sync[N_SYNC-1];

        // NOTE: every state register uses <= so all flops sample pre-edge values
        // regardless of block ordering; reset is synchronous, checked inside the clocked block.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                sync <= '0;
            end else begin
                sync <= {sync[N_SYNC-2:0], level_in[i]};
            end
        end

        // c counts consecutive mismatch cycles; the DB_CYC-th one accepts the new level.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                f   <= 1'b0;
                f_d <= 1'b0;
                c   <= '0;
            end else begin
                f_d <= f;
                if (s == f) begin
                    c <= '0;
                end else if (c == DB_LAST) begin
                    f <= s;
                    c <= '0;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end

        assign rise = f & ~f_d;
        assign fall = ~f & f_d;
        assign evt  = (rise & mode[2*i]) | (fall & mode[2*i+1]);

        // An event in the same cycle as a clear wins: sticky stays set, count restarts at 1.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                pulse_q  <= 1'b0;
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                pulse_q <= evt;
                if (evt) begin
                    sticky_q <= 1'b1;
                end else if (clr_sticky[i]) begin
                    sticky_q <= 1'b0;
                end
                if (clr_cnt[i]) begin
                    cnt_q <= CNT_W'(evt);
                end else if (evt && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign pulse_out[i]                    = pulse_q;
        assign sticky_out[i]                   = sticky_q;
        assign level_filt[i]                   = f;
        assign edge_cnt[CNT_W*i +: CNT_W]      = cnt_q;
    end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench: stimulus pushes expected pulses, a negedge monitor pops and compares.
// A second instance with CNT_W=2 shares all inputs to exercise counter saturation.
module tb_multi_edge_detect;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] level_in;
    logic [7:0] mode;
    logic [3:0] clr_sticky;
    logic [3:0] clr_cnt;

    logic [3:0]  pulse_out, sticky_out, level_filt;
    logic [31:0] edge_cnt;
    logic [3:0]  pulse_sat, sticky_sat, filt_sat;
    logic [7:0]  cnt_sat;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int         cyc;
        logic [3:0] pulse;
        int         ch;
        logic [7:0] cnt;
        logic [1:0] cnt_sat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_edge_detect dut (
        .clk        (clk),
        .rstn       (rstn),
        .level_in   (level_in),
        .mode       (mode),
        .clr_sticky (clr_sticky),
        .clr_cnt    (clr_cnt),
        .pulse_out  (pulse_out),
        .sticky_out (sticky_out),
        .level_filt (level_filt),
        .edge_cnt   (edge_cnt)
    );

    multi_edge_detect #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .rstn       (rstn),
        .level_in   (level_in),
        .mode       (mode),
        .clr_sticky (clr_sticky),
        .clr_cnt    (clr_cnt),
        .pulse_out  (pulse_sat),
        .sticky_out (sticky_sat),
        .level_filt (filt_sat),
        .edge_cnt   (cnt_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input int ch, input int cnt, input int cnt_s);
        exp_t e;
        e.cyc     = at;
        e.pulse   = 4'(1 << ch);
        e.ch      = ch;
        e.cnt     = 8'(cnt);
        e.cnt_sat = 2'(cnt_s);
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulse"},  {28'd0, pulse_out},  32'd0);
        check({tag, "_sticky"}, {28'd0, sticky_out}, 32'd0);
        check({tag, "_filt"},   {28'd0, level_filt}, 32'd0);
        check({tag, "_cnt"},    edge_cnt,            32'd0);
        check({tag, "_sat"},    {16'd0, pulse_sat, sticky_sat, filt_sat, cnt_sat}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en && ((pulse_out !== 4'b0) || (pulse_sat !== 4'b0))) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: pulse_out=%b pulse_sat=%b at cycle %0d, none expected",
                         pulse_out, pulse_sat, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle",   cyc,                               e.cyc);
                check("pulse_vec",     {28'd0, pulse_out},                {28'd0, e.pulse});
                check("pulse_vec_sat", {28'd0, pulse_sat},                {28'd0, e.pulse});
                check("pulse_cnt",     {24'd0, edge_cnt[8*e.ch +: 8]},    {24'd0, e.cnt});
                check("pulse_cnt_sat", {30'd0, cnt_sat[2*e.ch +: 2]},     {30'd0, e.cnt_sat});
                check("pulse_sticky",  {31'd0, sticky_out[e.ch]},         32'd1);
            end
        end
    end

    initial begin
        int t0;
        level_in   = 4'b0;
        mode       = 8'b01_11_01_01;
        clr_sticky = 4'b0;
        clr_cnt    = 4'b0;
        rstn       = 1'b0;
        step(3);
        check_all_zero("reset");
        rstn   = 1'b1;
        mon_en = 1'b1;
        step(4);

        // Basic rise on ch0: filtered level after edge 6, pulse after edge 7.
        level_in[0] = 1'b1;
        t0 = cyc;
        push(t0 + 7, 0, 1, 1);
        step(5);
        check("filt0_before", {31'd0, level_filt[0]}, 32'd0);
        step(1);
        check("filt0_after", {31'd0, level_filt[0]}, 32'd1);
        step(2);
        check("sticky0", {31'd0, sticky_out[0]}, 32'd1);
        check("cnt0", {24'd0, edge_cnt[7:0]}, 32'd1);
        step(5);

        // Glitch of 3 cycles on ch1 is rejected; 4 cycles is accepted.
        level_in[1] = 1'b1;
        step(3);
        level_in[1] = 1'b0;
        step(12);
        check("glitch_filt1", {31'd0, level_filt[1]}, 32'd0);
        check("glitch_sticky1", {31'd0, sticky_out[1]}, 32'd0);
        check("glitch_cnt1", {24'd0, edge_cnt[15:8]}, 32'd0);
        level_in[1] = 1'b1;
        t0 = cyc;
        push(t0 + 7, 1, 1, 1);
        step(4);
        level_in[1] = 1'b0;
        step(15);
        check("accept_filt1", {31'd0, level_filt[1]}, 32'd0);
        check("accept_sticky1", {31'd0, sticky_out[1]}, 32'd1);
        check("accept_cnt1", {24'd0, edge_cnt[15:8]}, 32'd1);

        // Both-edge mode on ch2, then mode off while the filter keeps tracking.
        for (int k = 1; k <= 4; k++) begin
            level_in[2] = ~level_in[2];
            push(cyc + 7, 2, k, (k > 3) ? 3 : k);
            step(20);
            check("both_filt2", {31'd0, level_filt[2]}, {31'd0, level_in[2]});
        end
        mode[5:4] = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            level_in[2] = ~level_in[2];
            step(20);
            check("off_filt2", {31'd0, level_filt[2]}, {31'd0, level_in[2]});
        end
        check("off_cnt2", {24'd0, edge_cnt[23:16]}, 32'd4);
        check("off_cnt2_sat", {30'd0, cnt_sat[5:4]}, 32'd3);

        // Saturation on ch3; sixth pulse coincides with count and sticky clears.
        for (int k = 1; k <= 6; k++) begin
            level_in[3] = 1'b1;
            t0 = cyc;
            if (k < 6) begin
                push(t0 + 7, 3, k, (k > 3) ? 3 : k);
                step(20);
            end else begin
                push(t0 + 7, 3, 1, 1);
                step(6);
                clr_cnt[3]    = 1'b1;
                clr_sticky[3] = 1'b1;
                step(1);
                clr_cnt[3]    = 1'b0;
                clr_sticky[3] = 1'b0;
                step(13);
            end
            level_in[3] = 1'b0;
            step(20);
        end
        check("sticky3_held", {31'd0, sticky_out[3]}, 32'd1);
        clr_sticky[3] = 1'b1;
        step(1);
        clr_sticky[3] = 1'b0;
        check("sticky3_cleared", {31'd0, sticky_out[3]}, 32'd0);
        check("cnt3_after_clr", {24'd0, edge_cnt[31:24]}, 32'd1);

        // Reset in the middle of a ch0 debounce; level still high at release.
        level_in[0] = 1'b0;
        step(15);
        check("filt0_low", {31'd0, level_filt[0]}, 32'd0);
        level_in[0] = 1'b1;
        step(4);
        rstn = 1'b0;
        step(1);
        check_all_zero("midreset");
        rstn = 1'b1;
        push(cyc + 7, 0, 1, 1);
        step(15);

        check("sb_drained", sb.size(), 32'd0);
        check("final_filt", {28'd0, level_filt}, 32'h1);
        check("final_filt_sat", {28'd0, filt_sat}, 32'h1);
        check("final_sticky", {28'd0, sticky_out}, 32'h1);
        check("final_sticky_sat", {28'd0, sticky_sat}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_edge_detect.md
MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent input channels (>=1).
REQ-002 SHALL have parameter N_SYNC, default 2, meaning synchronizer flops per channel (>=2).
REQ-003 SHALL have parameter DB_CYC, default 4, meaning consecutive synchronized cycles a new level must hold before acceptance (>=1; 1 = no filtering).
REQ-004 SHALL have parameter CNT_W, default 8, meaning width of each per-channel edge counter (>=1).
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port level_in  input  NCH  asynchronous level inputs (VIO bits, buttons), bit i = channel i.
REQ-008 SHALL have port mode  input  2*NCH  per-channel detect mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 SHALL have port clr_sticky  input  NCH  per-channel sticky-flag clear, synchronous to clk.
REQ-010 SHALL have port clr_cnt  input  NCH  per-channel counter clear, synchronous to clk.
REQ-011 SHALL have port pulse_out  output  NCH  one-cycle event pulse per channel.
REQ-012 SHALL have port sticky_out  output  NCH  latched "event seen" flag per channel.
REQ-013 SHALL have port level_filt  output  NCH  synchronized, debounced level per channel.
REQ-014 SHALL have port edge_cnt  output  NCH*CNT_W  per-channel saturating event counts, channel i at bits [CNT_W*(i+1)-1:CNT_W*i].

Function
REQ-015 SHALL treat all channels identically and independently; no cross-channel interaction.
REQ-016 SHALL pass level_in[i] through an N_SYNC-stage flop chain; s = last stage.
REQ-017 SHALL keep filtered level f (drives level_filt) and debounce counter c: s==f -> c<=0; s!=f -> c<=c+1, and when this is the DB_CYC-th consecutive mismatch cycle, f<=s and c<=0.
REQ-018 SHALL ignore any excursion of s shorter than DB_CYC cycles (f unchanged, counter restarts on return).
REQ-019 SHALL keep f_d <= f every cycle; rise = f & ~f_d, fall = ~f & f_d.
REQ-020 SHALL register event = (rise & mode[0]) | (fall & mode[1]) into pulse_out, producing exactly one cycle high per accepted transition.
REQ-021 SHALL, with level_in changed and stable before edge 1, update level_filt after edge N_SYNC+DB_CYC and assert pulse_out after edge N_SYNC+DB_CYC+1 (7 with defaults).
REQ-022 SHALL use mode as sampled on the cycle the event is evaluated; mode 00 suppresses pulse, sticky and count while level_filt keeps tracking.
REQ-023 SHALL set sticky_out[i] on the cycle pulse_out[i] asserts and clear it on clr_sticky[i]; simultaneous set and clear -> sticky stays 1.
REQ-024 SHALL increment channel count on each pulse, saturating at 2^CNT_W-1 (no wrap).
REQ-025 SHALL zero channel count on clr_cnt[i]; simultaneous clear and event -> count becomes 1.
REQ-026 SHALL make no combinational path from any input to any output.

Reset
REQ-027 SHALL, while rstn=0 at a clock edge, clear sync chains, f, f_d, c, pulse_out, sticky_out and edge_cnt to 0.
REQ-028 SHALL, when a level_in bit is high at reset release, report it as a rising transition after the REQ-021 latency.
REQ-029 SHALL abort any in-progress debounce or pulse on reset assertion mid-operation, with no pulse emitted after reset release for pre-reset activity.

Verification
REQ-030 Defaults, mode=01, level_in[0] 0->1 held -> level_filt[0]=1 after edge 6, pulse_out[0]=1 after edge 7 for exactly one cycle, edge_cnt ch0=1, sticky_out[0]=1.
REQ-031 Defaults, level_in[1] high for 3 cycles then low -> no level_filt, pulse, sticky or count change on ch1; 4-cycle high -> one pulse.
REQ-032 mode=11 on ch2, toggle level every 20 cycles for 4 transitions -> 4 pulses, edge_cnt ch2=4; mode=00 repeat -> 0 further pulses, level_filt still follows.
REQ-033 CNT_W=2, 5 rising events on ch3 -> edge_cnt ch3 sequence 1,2,3,3,3; clr_cnt on the same cycle as the 6th pulse -> count=1.
REQ-034 clr_sticky asserted on the same cycle as pulse -> sticky_out stays 1; clr_sticky alone later -> 0 next cycle.
REQ-035 rstn low for 1 cycle midway through debounce of ch0 -> all outputs 0; level high at release -> single pulse after edge 7 counted from release.
